// File: rtl/rice_csr_counter_pkg.sv
// Shared types and counter index constants for the CSR counter unit.
package rice_csr_counter_pkg;

    typedef logic [63:0] rice_counter_t;

    localparam logic [4:0] RICE_COUNTER_CYCLE    = 5'd0;
    localparam logic [4:0] RICE_COUNTER_INSTRET  = 5'd2;
    localparam logic [4:0] RICE_COUNTER_HPM_BASE = 5'd3;

    function automatic logic [31:0] rice_half(input rice_counter_t value, input logic high);
        return high ? value[63:32] : value[31:0];
    endfunction

endpackage

// File: rtl/rice_csr_counter_unit_if.sv
// CSR counter read/write bus: the master drives write/read selects, the unit returns read data.
interface rice_csr_counter_if #(
    parameter int XLEN = 32
);
    logic            i_write_valid;
    logic [4:0]      i_write_index;
    logic            i_write_high;
    logic [XLEN-1:0] i_write_data;
    logic [4:0]      i_read_index;
    logic            i_read_high;
    logic [XLEN-1:0] o_read_data;

    modport master (
        output i_write_valid, i_write_index, i_write_high, i_write_data,
        output i_read_index, i_read_high,
        input  o_read_data
    );

    modport slave (
        input  i_write_valid, i_write_index, i_write_high, i_write_data,
        input  i_read_index, i_read_high,
        output o_read_data
    );
endinterface

// File: rtl/rice_csr_counter_unit_counter.sv
// One 64-bit CSR counter with half/full write and an optional sticky wrap flag.
// Wrap flag exists only when RICE_CSR_COUNTER_OVERFLOW_EN is defined and OVERFLOW_EN is set.
module rice_csr_counter
    import rice_csr_counter_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter bit OVERFLOW_EN = 1'b0
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_increment,
    input  logic            i_write,
    input  logic            i_write_high,
    input  logic [XLEN-1:0] i_write_data,
    output rice_counter_t   o_value,
    output logic            o_overflow
);

    rice_counter_t count_q;
    rice_counter_t write_value;

    generate
        if (XLEN == 64) begin : g_full_write
            logic unused_write_high;
            assign unused_write_high = i_write_high;
            assign write_value       = rice_counter_t'(i_write_data);
        end else begin : g_half_write
            // The half not selected keeps its current value.
            assign write_value = i_write_high ? {i_write_data[31:0], count_q[31:0]}
                                              : {count_q[63:32], i_write_data[31:0]};
        end
    endgenerate

    // A write takes priority over the increment in the same cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            count_q <= '0;
        end else if (i_write) begin
            count_q <= write_value;
        end else if (i_increment) begin
            count_q <= count_q + 64'd1;
        end
    end

    assign o_value = count_q;

`ifdef RICE_CSR_COUNTER_OVERFLOW_EN
    generate
        if (OVERFLOW_EN) begin : g_overflow
            logic overflow_q;
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    overflow_q <= 1'b0;
                end else if (i_write) begin
                    overflow_q <= 1'b0;
                end else if (i_increment && (count_q == '1)) begin
                    overflow_q <= 1'b1;
                end
            end
            assign o_overflow = overflow_q;
        end else begin : g_no_overflow
            assign o_overflow = 1'b0;
        end
    endgenerate
`else
    localparam bit unused_overflow_en = OVERFLOW_EN;
    assign o_overflow = 1'b0;
`endif

endmodule

// File: rtl/rice_csr_counter_unit.sv
// Machine counter block: cycle, instret and HPM_COUNTERS hpm counters behind a CSR bus.
// Optional sticky hpm overflow flags when RICE_CSR_COUNTER_OVERFLOW_EN is defined.
module rice_csr_counter_unit
    import rice_csr_counter_pkg::*;
#(
    parameter  int XLEN         = 32,
    parameter  int HPM_COUNTERS = 4,
    localparam int HPM_W        = (HPM_COUNTERS > 0) ? HPM_COUNTERS : 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_retire,
    input  logic [HPM_W-1:0]  i_hpm_event,
    input  logic [31:0]       i_inhibit,
    rice_csr_counter_if.slave csr,
    output logic [HPM_W-1:0]  o_overflow
);

    rice_counter_t cycle_value;
    rice_counter_t instret_value;
    rice_counter_t hpm_value [HPM_W];
    rice_counter_t read_value;
    logic          unused_cycle_overflow;
    logic          unused_instret_overflow;
    logic          unused_inhibit;

    // Bit 1 and bits beyond the last implemented hpm have no counter behind them.
    assign unused_inhibit = ^i_inhibit;

    rice_csr_counter #(.XLEN(XLEN), .OVERFLOW_EN(1'b0)) u_cycle (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_increment  (!i_inhibit[0]),
        .i_write      (csr.i_write_valid && (csr.i_write_index == RICE_COUNTER_CYCLE)),
        .i_write_high (csr.i_write_high),
        .i_write_data (csr.i_write_data),
        .o_value      (cycle_value),
        .o_overflow   (unused_cycle_overflow)
    );

    rice_csr_counter #(.XLEN(XLEN), .OVERFLOW_EN(1'b0)) u_instret (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_increment  (i_retire && !i_inhibit[2]),
        .i_write      (csr.i_write_valid && (csr.i_write_index == RICE_COUNTER_INSTRET)),
        .i_write_high (csr.i_write_high),
        .i_write_data (csr.i_write_data),
        .o_value      (instret_value),
        .o_overflow   (unused_instret_overflow)
    );

    generate
        if (HPM_COUNTERS > 0) begin : g_hpm
            for (genvar k = 0; k < HPM_COUNTERS; k++) begin : g_ctr
                localparam logic [4:0] HPM_INDEX = RICE_COUNTER_HPM_BASE + 5'(k);
                rice_csr_counter #(.XLEN(XLEN), .OVERFLOW_EN(1'b1)) u_hpm (
                    .i_clk        (i_clk),
                    .i_rst        (i_rst),
                    .i_increment  (i_hpm_event[k] && !i_inhibit[3+k]),
                    .i_write      (csr.i_write_valid && (csr.i_write_index == HPM_INDEX)),
                    .i_write_high (csr.i_write_high),
                    .i_write_data (csr.i_write_data),
                    .o_value      (hpm_value[k]),
                    .o_overflow   (o_overflow[k])
                );
            end
        end else begin : g_no_hpm
            logic unused_hpm_event;
            assign unused_hpm_event = i_hpm_event[0];
            assign hpm_value[0]     = '0;
            assign o_overflow       = '0;
        end
    endgenerate

    // Index 1 and unimplemented hpm indices fall through to zero.
    always_comb begin
        read_value = '0;
        if (csr.i_read_index == RICE_COUNTER_CYCLE) begin
            read_value = cycle_value;
        end else if (csr.i_read_index == RICE_COUNTER_INSTRET) begin
            read_value = instret_value;
        end else begin
            for (int k = 0; k < HPM_COUNTERS; k++) begin
                if (csr.i_read_index == (RICE_COUNTER_HPM_BASE + 5'(k))) begin
                    read_value = hpm_value[k];
                end
            end
        end
    end

    generate
        if (XLEN == 64) begin : g_read_full
            logic unused_read_high;
            assign unused_read_high = csr.i_read_high;
            assign csr.o_read_data  = read_value[XLEN-1:0];
        end else begin : g_read_half
            assign csr.o_read_data = rice_half(read_value, csr.i_read_high);
        end
    endgenerate

endmodule
